riscv_core_exec_mem: RTL and testbench
======================================

# riscv_core_exec_mem

Combined PC register, 32-bit integer ALU and word-addressed data memory for the single-cycle RISC-V core. It holds the program counter, evaluates ALU operations combinationally, and services LW/SW accesses. Decode, the register file, instruction memory and sign extension sit outside this block and drive its control inputs.

## Interface
- DMEM_WORDS, 256: data memory depth in 32-bit words; must be a power of two.
- RESET_PC, 32'h0000_0000: PC value while reset is asserted.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- finish_flag  in  1  program finished; freezes the PC.
- branch  in  1  branch taken this cycle.
- branch_offset  in  32  signed byte offset added to the PC when a branch is taken.
- pc_reg  out  32  current PC (byte address).
- alu_ctl  in  4  ALU operation select.
- alu_a  in  32  ALU operand A.
- alu_b  in  32  ALU operand B.
- alu_out  out  32  ALU result.
- alu_zero  out  1  high when alu_out == 0.
- mem_write_enable  in  1  store strobe.
- mem_read_enable  in  1  load enable.
- mem_address  in  32  byte address for a load or store.
- mem_write_data  in  32  store data.
- mem_read_data  out  32  load data.

## Operation
- PC, rising edge of clk, priority order:
  - finish_flag=1: hold.
  - Else branch=1: pc_reg <= pc_reg + branch_offset.
  - Else: pc_reg <= pc_reg + 4.
  - Addition is modulo 2^32; wrap-around is silent.
  - A negative offset moves the PC backwards.
  - branch is ignored while finish_flag=1.
- ALU is purely combinational. alu_ctl values:
  - 0 AND, 1 OR, 2 ADD, 6 SUB (A−B), 7 SLT (signed A<B gives 1, else 0), 12 NOR.
  - Any other code gives alu_out = 0.
  - ADD and SUB wrap modulo 2^32; no overflow or carry outputs.
  - alu_zero is derived from alu_out for every code, including undefined codes (which therefore give alu_zero=1).
- Data memory: DMEM_WORDS × 32-bit array.
  - Word index = mem_address[log2(DMEM_WORDS)+1:2].
  - Bits [1:0] are ignored (misaligned accesses are forced to word alignment).
  - Upper address bits are ignored, so out-of-range addresses alias modulo the depth.
  - Store: the array is written at the rising edge when mem_write_enable=1.
  - Load: mem_read_data = array[index] combinationally while mem_read_enable=1; 0 otherwise.
  - Read and write to the same word in one cycle: the read returns the old word until the edge and the new word after it.
- Reset (rst_n=0, asynchronous): pc_reg = RESET_PC and every memory word is cleared to 0.
  - ALU outputs follow their inputs during reset.
  - mem_read_data is 0 during reset.
  - Stores are ignored while rst_n=0.
  - After release, the first rising edge advances the PC normally.
  - Reset asserted mid-program discards the PC immediately.

## Timing
- PC: one-cycle update latency. pc_reg changes only on a rising clk edge or on the falling edge of rst_n.
- ALU: zero-cycle combinational path from alu_ctl/alu_a/alu_b to alu_out/alu_zero.
- Load: zero-cycle combinational path from mem_address/mem_read_enable to mem_read_data.
- Store: one-cycle latency; data is visible to reads after the edge.
- No handshakes. Control inputs are sampled once per cycle. Inputs must be stable at the edge, since the block is intended for single-cycle use.

## Structure
- Shared package riscv_core_pkg:
  - XLEN = 32.
  - ALU op constants ALU_AND=4'd0, ALU_OR=4'd1, ALU_ADD=4'd2, ALU_SUB=4'd6, ALU_SLT=4'd7, ALU_NOR=4'd12.
- The ALU is a natural sub-module: riscv_core_alu (alu_ctl, alu_a, alu_b, alu_out, alu_zero).
- The PC register and memory array are kept in the top level of this block.

## Test plan
- Reset then 3 clocks with branch=0, finish_flag=0 → pc_reg = 0, 4, 8, 12.
- pc_reg=12, branch=1, branch_offset=−8 for one edge → pc_reg=4; next edge with branch=0 → 8. Then finish_flag=1 with branch=1 → PC holds at 8 for 5 cycles.
- ALU checks:
  - A=0xF0, B=0x3C: AND → 0x30; OR → 0xFC; ADD → 0x12C.
  - SUB with A=B=5 → 0, alu_zero=1.
  - SUB with A=0, B=1 → 0xFFFF_FFFF.
  - SLT with A=−1, B=1 → 1.
- Memory:
  - Store 32'hDEAD_BEEF at address 8.
  - Next cycle, read at 8 and at 10 (misaligned) → DEAD_BEEF for both.
  - Read at 8+4·DMEM_WORDS → DEAD_BEEF (aliasing).
  - mem_read_enable=0 → 0.
- Same-cycle store and load to address 4 (old value 0, new 7) → mem_read_data=0 before the edge, 7 after it.
- Assert rst_n=0 mid-clock with pc_reg=20 and memory non-zero → pc_reg=0 immediately (no clock edge needed); all memory reads return 0.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Shared definitions for the single-cycle RISC-V core: data width and ALU operation codes.
package riscv_core_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    // Signed less-than, returned as a full-width 0/1 word.
    function automatic logic [XLEN-1:0] slt_word(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] res;
        if ($signed(a) < $signed(b)) begin
            res = {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            res = {XLEN{1'b0}};
        end
        return res;
    endfunction

endpackage

// File: rtl/riscv_core_alu.sv
// Purely combinational 32-bit integer ALU; unknown opcodes produce zero.
module riscv_core_alu
    import riscv_core_pkg::*;
(
    input  logic [3:0]      alu_ctl,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] alu_out,
    output logic            alu_zero
);

    logic [XLEN-1:0] result_s;

    // Operation select; add/sub wrap silently.
    always_comb begin
        result_s = {XLEN{1'b0}};
        case (alu_ctl)
            ALU_AND: result_s = alu_a & alu_b;
            ALU_OR:  result_s = alu_a | alu_b;
            ALU_ADD: result_s = alu_a + alu_b;
            ALU_SUB: result_s = alu_a - alu_b;
            ALU_SLT: result_s = slt_word(alu_a, alu_b);
            ALU_NOR: result_s = ~(alu_a | alu_b);
            default: result_s = {XLEN{1'b0}};
        endcase
    end

    assign alu_out  = result_s;
    assign alu_zero = (result_s == {XLEN{1'b0}});

endmodule

// File: rtl/riscv_core_exec_mem.sv
// PC register, ALU and word-addressed data memory of the single-cycle core.
module riscv_core_exec_mem
    import riscv_core_pkg::*;
#(
    parameter int              DMEM_WORDS = 256,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            finish_flag,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_offset,
    output logic [XLEN-1:0] pc_reg,
    input  logic [3:0]      alu_ctl,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] alu_out,
    output logic            alu_zero,
    input  logic            mem_write_enable,
    input  logic            mem_read_enable,
    input  logic [XLEN-1:0] mem_address,
    input  logic [XLEN-1:0] mem_write_data,
    output logic [XLEN-1:0] mem_read_data
);

    localparam int IDX_W = $clog2(DMEM_WORDS);

    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  pc_next_s;
    logic [XLEN-1:0]  mem_r [DMEM_WORDS];
    logic [IDX_W-1:0] word_idx_s;
    logic [XLEN-1:0]  read_data_s;

    // Byte offset and high bits are dropped: accesses align and alias modulo depth.
    assign word_idx_s = mem_address[IDX_W+1:2];

    // Next PC: finish freezes, branch offsets, otherwise step one word.
    always_comb begin
        pc_next_s = pc_r;
        if (finish_flag) begin
            pc_next_s = pc_r;
        end else if (branch) begin
            pc_next_s = pc_r + branch_offset;
        end else begin
            pc_next_s = pc_r + 32'd4;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Data memory array, fully cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
        end else if (mem_write_enable) begin
            mem_r[word_idx_s] <= mem_write_data;
        end
    end

    // Combinational load port, forced to zero while disabled or in reset.
    always_comb begin
        read_data_s = {XLEN{1'b0}};
        if (rst_n && mem_read_enable) begin
            read_data_s = mem_r[word_idx_s];
        end else begin
            read_data_s = {XLEN{1'b0}};
        end
    end

    assign pc_reg        = pc_r;
    assign mem_read_data = read_data_s;

    riscv_core_alu u_alu (
        .alu_ctl  (alu_ctl),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_out  (alu_out),
        .alu_zero (alu_zero)
    );

endmodule

// File: tb/tb_riscv_core_exec_mem.sv
// Directed self-checking bench for riscv_core_exec_mem.
module tb_riscv_core_exec_mem;

    localparam int DMEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        finish_flag;
    logic        branch;
    logic [31:0] branch_offset;
    logic [31:0] pc_reg;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_core_exec_mem #(.DMEM_WORDS(DMEM_WORDS), .RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .finish_flag      (finish_flag),
        .branch           (branch),
        .branch_offset    (branch_offset),
        .pc_reg           (pc_reg),
        .alu_ctl          (alu_ctl),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_out          (alu_out),
        .alu_zero         (alu_zero),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        finish_flag = 1'b0;
        branch = 1'b0;
        branch_offset = 32'd0;
        alu_ctl = 4'd0;
        alu_a = 32'd0;
        alu_b = 32'd0;
        mem_write_enable = 1'b0;
        mem_read_enable = 1'b1;
        mem_address = 32'd8;
        mem_write_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pc_reg !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc got=%h exp=%h", pc_reg, 32'h0);
        end
        checks++;
        if (mem_read_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=%h", mem_read_data, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_read_enable = 1'b0;
    endtask

    task automatic test_pc();
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (pc_reg !== 32'(4 * i)) begin
                failures++;
                $display("FAIL pc_step%0d got=%h exp=%h", i, pc_reg, 32'(4 * i));
            end
        end
        branch = 1'b1;
        branch_offset = 32'hFFFF_FFF8;
        @(posedge clk);
        #1;
        checks++;
        if (pc_reg !== 32'd4) begin
            failures++;
            $display("FAIL pc_branch_back got=%h exp=%h", pc_reg, 32'd4);
        end
        branch = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (pc_reg !== 32'd8) begin
            failures++;
            $display("FAIL pc_after_branch got=%h exp=%h", pc_reg, 32'd8);
        end
        finish_flag = 1'b1;
        branch = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (pc_reg !== 32'd8) begin
                failures++;
                $display("FAIL pc_hold%0d got=%h exp=%h", i, pc_reg, 32'd8);
            end
        end
        branch = 1'b0;
    endtask

    task automatic test_alu();
        logic [3:0]  ctl_v [8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd6, 4'd7, 4'd12, 4'd3};
        logic [31:0] a_v   [8] = '{32'hF0, 32'hF0, 32'hF0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'hF0, 32'h1234};
        logic [31:0] b_v   [8] = '{32'h3C, 32'h3C, 32'h3C, 32'd5, 32'd1, 32'd1, 32'h3C, 32'h5678};
        logic [31:0] exp_v [8] = '{32'h30, 32'hFC, 32'h12C, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FF03, 32'h0};
        logic        z_v   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            alu_ctl = ctl_v[i];
            alu_a = a_v[i];
            alu_b = b_v[i];
            #1;
            checks++;
            if (alu_out !== exp_v[i] || alu_zero !== z_v[i]) begin
                failures++;
                $display("FAIL alu_vec%0d got=%h/%b exp=%h/%b", i, alu_out, alu_zero, exp_v[i], z_v[i]);
            end
        end
    endtask

    task automatic test_memory();
        mem_write_enable = 1'b1;
        mem_address = 32'd8;
        mem_write_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_write_enable = 1'b0;
        mem_read_enable = 1'b1;
        #1;
        checks++;
        if (mem_read_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL mem_read8 got=%h exp=%h", mem_read_data, 32'hDEAD_BEEF);
        end
        mem_address = 32'd10;
        #1;
        checks++;
        if (mem_read_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL mem_misaligned got=%h exp=%h", mem_read_data, 32'hDEAD_BEEF);
        end
        mem_address = 32'(8 + 4 * DMEM_WORDS);
        #1;
        checks++;
        if (mem_read_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL mem_alias got=%h exp=%h", mem_read_data, 32'hDEAD_BEEF);
        end
        mem_read_enable = 1'b0;
        #1;
        checks++;
        if (mem_read_data !== 32'h0) begin
            failures++;
            $display("FAIL mem_read_disabled got=%h exp=%h", mem_read_data, 32'h0);
        end
    endtask

    task automatic test_same_cycle();
        @(posedge clk);
        #1;
        mem_write_enable = 1'b1;
        mem_read_enable = 1'b1;
        mem_address = 32'd4;
        mem_write_data = 32'd7;
        #1;
        checks++;
        if (mem_read_data !== 32'd0) begin
            failures++;
            $display("FAIL rw_before_edge got=%h exp=%h", mem_read_data, 32'd0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mem_read_data !== 32'd7) begin
            failures++;
            $display("FAIL rw_after_edge got=%h exp=%h", mem_read_data, 32'd7);
        end
        mem_write_enable = 1'b0;
        checks++;
        if (pc_reg !== 32'd8) begin
            failures++;
            $display("FAIL pc_frozen got=%h exp=%h", pc_reg, 32'd8);
        end
    endtask

    task automatic test_midreset();
        finish_flag = 1'b0;
        branch = 1'b1;
        branch_offset = 32'd12;
        @(posedge clk);
        #1;
        branch = 1'b0;
        checks++;
        if (pc_reg !== 32'd20) begin
            failures++;
            $display("FAIL pc_before_reset got=%h exp=%h", pc_reg, 32'd20);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc_reg !== 32'd0) begin
            failures++;
            $display("FAIL pc_async_reset got=%h exp=%h", pc_reg, 32'd0);
        end
        mem_read_enable = 1'b1;
        mem_address = 32'd4;
        #1;
        checks++;
        if (mem_read_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_read4 got=%h exp=%h", mem_read_data, 32'd0);
        end
        mem_write_enable = 1'b1;
        mem_address = 32'd12;
        mem_write_data = 32'h0000_0055;
        @(posedge clk);
        #1;
        mem_write_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (mem_read_data !== 32'd0) begin
            failures++;
            $display("FAIL store_in_reset got=%h exp=%h", mem_read_data, 32'd0);
        end
        mem_address = 32'd8;
        #1;
        checks++;
        if (mem_read_data !== 32'd0) begin
            failures++;
            $display("FAIL mem_cleared8 got=%h exp=%h", mem_read_data, 32'd0);
        end
        mem_address = 32'd4;
        #1;
        checks++;
        if (mem_read_data !== 32'd0) begin
            failures++;
            $display("FAIL mem_cleared4 got=%h exp=%h", mem_read_data, 32'd0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pc_reg !== 32'd4) begin
            failures++;
            $display("FAIL pc_after_release got=%h exp=%h", pc_reg, 32'd4);
        end
    endtask

    initial begin
        test_reset();
        test_pc();
        test_alu();
        test_memory();
        test_same_cycle();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
